cache_flush_seq: RTL

CACHE_FLUSH_SEQ -- requirements
Module: cache_flush_seq

---
 rtl/cache_flush_if.sv | 31 +++
 rtl/cache_flush_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cache_flush_if.sv
// cache_flush_if: flush-sequencer <-> cache-array handshake bundle.
// master = flush sequencer (drives set/way selection and writeback control),
// slave  = cache array / writeback side (returns tag state and acknowledges).
interface cache_flush_if #(
    parameter int NUMWAYS = 4,
    parameter int SETLEN  = 7
);
    logic               FlushReq;
    logic [NUMWAYS-1:0] ValidWay;
    logic [NUMWAYS-1:0] DirtyWay;
    logic               WBAck;
    logic [SETLEN-1:0]  FlushAdr;
    logic [NUMWAYS-1:0] FlushWay;
    logic               WBReq;
    logic               ClearDirty;
    logic               FlushBusy;
    logic               FlushDone;
    logic               InvalidateCache;

    modport master (
        input  FlushReq, ValidWay, DirtyWay, WBAck,
        output FlushAdr, FlushWay, WBReq, ClearDirty,
        output FlushBusy, FlushDone, InvalidateCache
    );

    modport slave (
        output FlushReq, ValidWay, DirtyWay, WBAck,
        input  FlushAdr, FlushWay, WBReq, ClearDirty,
        input  FlushBusy, FlushDone, InvalidateCache
    );
endinterface

// File: rtl/cache_flush_seq.sv
// cache_flush_seq: walks every set/way of the cache, writes back each line that
// is both dirty and valid, then pulses FlushDone.
// Per set: one READ cycle presents FlushAdr, then one CHECK cycle per way using
// the tag state returned one cycle after the address.
// Optional feature: define CACHE_FLUSH_INVALIDATE_EN to pulse InvalidateCache
// together with FlushDone; otherwise InvalidateCache is tied low.
module cache_flush_seq #(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = 7
) (
    input  logic          clk,
    input  logic          reset,
    cache_flush_if.master f
);
    localparam int WAYLEN = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WB,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [SETLEN-1:0]  set_q;
    logic [WAYLEN-1:0]  way_q;
    logic [NUMWAYS-1:0] way_oh_q;
    logic               busy_q;
    logic               wbreq_q;
    logic               done_q;

    // Target of an "advance" step (shared by CHECK and acknowledged WB).
    state_t             state_d;
    logic [SETLEN-1:0]  set_d;
    logic [WAYLEN-1:0]  way_d;
    logic [NUMWAYS-1:0] way_oh_d;

    logic               last_way;
    logic               last_set;
    logic               hit;
    logic [NUMWAYS-1:0] way_oh_inc;

    assign last_way = (way_q == WAYLEN'(NUMWAYS - 1));
    assign last_set = (set_q == SETLEN'(NUMLINES - 1));
    // The one-hot way mask selects the bit under examination.
    assign hit      = |(f.DirtyWay & f.ValidWay & way_oh_q);

    // One-hot of way+1: shift the current one-hot up by one position.
    generate
        for (genvar gi = 0; gi < NUMWAYS; gi++) begin : g_way_shift
            if (gi == 0) begin : g_lsb
                assign way_oh_inc[gi] = 1'b0;
            end else begin : g_up
                assign way_oh_inc[gi] = way_oh_q[gi-1];
            end
        end
    endgenerate

    // Advance: next way in this set, else first way of next set, else finish.
    always_comb begin
        state_d  = S_CHECK;
        set_d    = set_q;
        way_d    = way_q + WAYLEN'(1);
        way_oh_d = way_oh_inc;
        if (last_way) begin
            if (last_set) begin
                state_d  = S_DONE;
                way_d    = way_q;
                way_oh_d = way_oh_q;
            end else begin
                state_d  = S_READ;
                set_d    = set_q + SETLEN'(1);
                way_d    = '0;
                way_oh_d = NUMWAYS'(1);
            end
        end
    end

    // Flush FSM with registered outputs; counters never wrap, the last set/way ends the walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            set_q    <= '0;
            way_q    <= '0;
            way_oh_q <= NUMWAYS'(1);
            busy_q   <= 1'b0;
            wbreq_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (f.FlushReq) begin
                        state_q  <= S_READ;
                        set_q    <= '0;
                        way_q    <= '0;
                        way_oh_q <= NUMWAYS'(1);
                        busy_q   <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (hit) begin
                        state_q <= S_WB;
                        wbreq_q <= 1'b1;
                    end else begin
                        state_q  <= state_d;
                        set_q    <= set_d;
                        way_q    <= way_d;
                        way_oh_q <= way_oh_d;
                        busy_q   <= (state_d != S_DONE);
                        done_q   <= (state_d == S_DONE);
                    end
                end
                S_WB: begin
                    // Wait for the acknowledge with no timeout; address/way stay put.
                    if (f.WBAck) begin
                        wbreq_q  <= 1'b0;
                        state_q  <= state_d;
                        set_q    <= set_d;
                        way_q    <= way_d;
                        way_oh_q <= way_oh_d;
                        busy_q   <= (state_d != S_DONE);
                        done_q   <= (state_d == S_DONE);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign f.FlushAdr  = set_q;
    assign f.FlushWay  = way_oh_q;
    assign f.WBReq     = wbreq_q;
    assign f.FlushBusy = busy_q;
    assign f.FlushDone = done_q;
    // ClearDirty must coincide with the accepting cycle, so it follows WBAck directly.
    assign f.ClearDirty = wbreq_q & f.WBAck;

`ifdef CACHE_FLUSH_INVALIDATE_EN
    assign f.InvalidateCache = done_q;
`else
    assign f.InvalidateCache = 1'b0;
`endif

endmodule
